// File: rtl/stim_capture_pkg.sv
// Shared register map, flag bit positions and FSM state type for the input-capture peripheral.
package stim_capture_pkg;

  localparam logic [2:0] REG_PSC     = 3'd0;
  localparam logic [2:0] REG_CTRL    = 3'd1;
  localparam logic [2:0] REG_STAT    = 3'd2;
  localparam logic [2:0] REG_PERIOD  = 3'd3;
  localparam logic [2:0] REG_HIGH    = 3'd4;
  localparam logic [2:0] REG_TIMEOUT = 3'd5;

  localparam int CTRL_EN    = 0;
  localparam int CTRL_INV   = 1;
  localparam int STAT_VALID = 0;
  localparam int STAT_OVR   = 1;
  localparam int STAT_TMO   = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } cap_state_t;

  // Merge a bus write into an existing register value, one byte lane per strobe bit.
  function automatic logic [31:0] apply_be(input logic [31:0] old_v,
                                           input logic [31:0] new_v,
                                           input logic [3:0]  be);
    logic [31:0] r;
    r = old_v;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) r[8*i +: 8] = new_v[8*i +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/stim_capture_if.sv
// 32-bit peripheral bus bundle: byte write strobes, byte address, write data and read data.
interface stim_capture_if;
  logic [3:0]  Write;
  logic [31:0] Addr;
  logic [31:0] WData;
  logic [31:0] RData;

  modport master (output Write, Addr, WData, input RData);
  modport slave  (input Write, Addr, WData, output RData);
endinterface

// File: rtl/stim_capture_core.sv
// Capture engine: synchroniser, optional glitch filter (STIM_CAPTURE_FILTER_EN), prescaler,
// measurement counter and IDLE/HIGH/LOW FSM.
module cap_core
  import stim_capture_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] psc_i,
  input  logic [31:0] timeout_i,
  input  logic        en_i,
  input  logic        inv_i,
  input  logic        cap_i,
  output logic [31:0] period_o,
  output logic [31:0] high_o,
  output logic        meas_o,
  output logic        tmo_o
);

  logic s1_q, s2_q, s3_q;
  logic rise, fall;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= cap_i ^ inv_i;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

`ifdef STIM_CAPTURE_FILTER_EN
  // Filtered level flips only once s2 has held the new value for three samples.
  logic s4_q, filt_q;
  logic stable_hi, stable_lo;
  assign stable_hi = s2_q & s3_q & s4_q;
  assign stable_lo = ~(s2_q | s3_q | s4_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      s4_q   <= 1'b0;
      filt_q <= 1'b0;
    end else begin
      s4_q <= s3_q;
      if (stable_hi)      filt_q <= 1'b1;
      else if (stable_lo) filt_q <= 1'b0;
    end
  end

  assign rise = stable_hi & ~filt_q;
  assign fall = stable_lo & filt_q;
`else
  assign rise = s2_q & ~s3_q;
  assign fall = ~s2_q & s3_q;
`endif

  cap_state_t  state_q;
  logic [31:0] psc_cnt_q, cnt_q, hi_snap_q, period_q, high_q;
  logic [31:0] cnt_d;
  logic        tick, timed_out;

  assign tick      = (psc_cnt_q == psc_i);
  assign cnt_d     = (tick && (cnt_q != 32'hFFFF_FFFF)) ? cnt_q + 32'd1 : cnt_q;
  assign timed_out = (timeout_i != 32'd0) && (cnt_d >= timeout_i);

  assign meas_o   = en_i && (state_q == LOW) && rise;
  assign tmo_o    = en_i && timed_out &&
                    ((state_q == HIGH) || ((state_q == LOW) && !rise));
  assign period_o = period_q;
  assign high_o   = high_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      psc_cnt_q <= 32'd0;
      cnt_q     <= 32'd0;
      hi_snap_q <= 32'd0;
      period_q  <= 32'd0;
      high_q    <= 32'd0;
    end else if (!en_i) begin
      state_q   <= IDLE;
      psc_cnt_q <= 32'd0;
      cnt_q     <= 32'd0;
    end else begin
      psc_cnt_q <= (rise || tick) ? 32'd0 : psc_cnt_q + 32'd1;
      cnt_q     <= rise ? 32'd0 : cnt_d;
      case (state_q)
        IDLE: if (rise) state_q <= HIGH;
        HIGH: begin
          if (timed_out) begin
            state_q <= IDLE;
          end else if (fall) begin
            hi_snap_q <= cnt_d;
            state_q   <= LOW;
          end
        end
        LOW: begin
          // A rise in the same cycle as the timeout still completes the measurement.
          if (rise) begin
            period_q <= cnt_d;
            high_q   <= hi_snap_q;
            state_q  <= HIGH;
          end else if (timed_out) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/stim_capture.sv
// Input-capture peripheral top: register file, W1C status flags and read mux around cap_core.
// Optional glitch filter in the core is enabled by defining STIM_CAPTURE_FILTER_EN.
module stim_capture
  import stim_capture_pkg::*;
#(
  parameter int MEMORY_TYPE = 0
) (
  input  logic           clk,
  input  logic           rst,
  stim_capture_if.slave  bus,
  input  logic           cap_in
);

  logic [31:0] psc_q, timeout_q;
  logic [1:0]  ctrl_q;
  logic [2:0]  stat_q, stat_set, stat_clr;
  logic [31:0] period, high_time, rdata_c;
  logic        meas, tmo, wr_any;
  logic [2:0]  sel;

  wire unused_addr = ^{bus.Addr[31:5], bus.Addr[1:0]};

  assign sel    = bus.Addr[4:2];
  assign wr_any = |bus.Write;

  cap_core u_core (
    .clk       (clk),
    .rst       (rst),
    .psc_i     (psc_q),
    .timeout_i (timeout_q),
    .en_i      (ctrl_q[CTRL_EN]),
    .inv_i     (ctrl_q[CTRL_INV]),
    .cap_i     (cap_in),
    .period_o  (period),
    .high_o    (high_time),
    .meas_o    (meas),
    .tmo_o     (tmo)
  );

  always_comb begin
    stat_set             = 3'd0;
    stat_set[STAT_VALID] = meas;
    stat_set[STAT_OVR]   = meas & stat_q[STAT_VALID];
    stat_set[STAT_TMO]   = tmo;
  end

  assign stat_clr = (wr_any && (sel == REG_STAT) && bus.Write[0]) ? bus.WData[2:0] : 3'd0;

  always_ff @(posedge clk) begin
    if (rst) begin
      psc_q     <= 32'd0;
      timeout_q <= 32'd0;
      ctrl_q    <= 2'd0;
      stat_q    <= 3'd0;
    end else begin
      if (wr_any && (sel == REG_PSC))     psc_q     <= apply_be(psc_q, bus.WData, bus.Write);
      if (wr_any && (sel == REG_TIMEOUT)) timeout_q <= apply_be(timeout_q, bus.WData, bus.Write);
      if (wr_any && (sel == REG_CTRL) && bus.Write[0]) ctrl_q <= bus.WData[1:0];
      // Hardware set is OR-ed in after the clear so it wins a same-cycle collision.
      stat_q <= (stat_q & ~stat_clr) | stat_set;
    end
  end

  always_comb begin
    rdata_c = 32'd0;
    case (sel)
      REG_PSC:     rdata_c = psc_q;
      REG_CTRL:    rdata_c = {30'd0, ctrl_q};
      REG_STAT:    rdata_c = {29'd0, stat_q};
      REG_PERIOD:  rdata_c = period;
      REG_HIGH:    rdata_c = high_time;
      REG_TIMEOUT: rdata_c = timeout_q;
      default:     rdata_c = 32'd0;
    endcase
  end

  generate
    if (MEMORY_TYPE == 1) begin : g_rd_reg
      logic [31:0] rdata_q;
      always_ff @(posedge clk) begin
        if (rst) rdata_q <= 32'd0;
        else     rdata_q <= rdata_c;
      end
      assign bus.RData = rdata_q;
    end else begin : g_rd_comb
      assign bus.RData = rdata_c;
    end
  endgenerate

endmodule

// File: tb/tb_stim_capture.sv
// Scoreboarded bench for stim_capture: reads push expected values, a negedge monitor checks RData.
module tb_stim_capture;
  import stim_capture_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cap_in = 1'b0;
  logic rd_strobe = 1'b0;

  stim_capture_if bus ();

  stim_capture #(.MEMORY_TYPE(0)) dut (
    .clk    (clk),
    .rst    (rst),
    .bus    (bus),
    .cap_in (cap_in)
  );

  always #5 clk = ~clk;

`ifdef STIM_CAPTURE_FILTER_EN
  localparam int ACT = 5;
`else
  localparam int ACT = 3;
`endif

  localparam logic [4:0] A_PSC = 5'h00, A_CTRL = 5'h04, A_STAT = 5'h08, A_PER = 5'h0C;
  localparam logic [4:0] A_HIGH = 5'h10, A_TMO = 5'h14;

  typedef struct {
    string       name;
    logic [31:0] exp;
  } rd_exp_t;

  rd_exp_t sb[$];
  int total = 0;
  int bad   = 0;

  always @(negedge clk) begin
    rd_exp_t e;
    if (rd_strobe) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL scoreboard_empty got=%h", bus.RData);
      end else begin
        e = sb.pop_front();
        if (bus.RData !== e.exp) begin
          bad++;
          $display("FAIL %s got=%h exp=%h", e.name, bus.RData, e.exp);
        end
      end
    end
  end

  task automatic rd(input logic [4:0] a, input logic [31:0] e, input string n);
    rd_exp_t t;
    @(posedge clk); #1;
    bus.Addr  = {27'd0, a};
    t.name    = n;
    t.exp     = e;
    sb.push_back(t);
    rd_strobe = 1'b1;
    @(negedge clk); #1;
    rd_strobe = 1'b0;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d, input logic [3:0] be);
    @(posedge clk); #1;
    bus.Addr  = {27'd0, a};
    bus.WData = d;
    bus.Write = be;
    @(posedge clk); #1;
    bus.Write = 4'h0;
  endtask

  task automatic hold(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Reference: a span of n clocks starting at a rise reads as floor(n / (psc+1)) ticks.
  function automatic logic [31:0] ticks(input int n, input int psc);
    return 32'(n / (psc + 1));
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.Write = 4'h0;
    bus.Addr  = 32'd0;
    bus.WData = 32'd0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    for (int i = 0; i < 8; i++) rd(5'(i * 4), 32'd0, $sformatf("reset_%0d", i));

    wr(A_PSC, 32'hFFFF_FFFF, 4'b0101);
    rd(A_PSC, 32'h00FF_00FF, "psc_bytes");
    wr(A_TMO, 32'hA5A5_A5A5, 4'b1000);
    rd(A_TMO, 32'hA500_0000, "tmo_bytes");
    wr(A_CTRL, 32'hFFFF_FFFE, 4'hF);
    rd(A_CTRL, 32'h2, "ctrl_mask");
    wr(A_PER, 32'hFFFF_FFFF, 4'hF);
    rd(A_PER, 32'd0, "period_ro");
    wr(5'h18, 32'hFFFF_FFFF, 4'hF);
    rd(5'h18, 32'd0, "unmapped");
    wr(A_CTRL, 32'd0, 4'hF);
    wr(A_PSC, 32'd0, 4'hF);
    wr(A_TMO, 32'd0, 4'hF);

    // basic measurement with exact result latency
    wr(A_CTRL, 32'h1, 4'hF);
    cap_in = 1'b1; hold(30); cap_in = 1'b0; hold(70); cap_in = 1'b1;
    for (int j = 1; j <= 5; j++) rd(A_STAT, (j >= ACT) ? 32'h1 : 32'h0, $sformatf("latency_%0d", j));
    hold(25); cap_in = 1'b0; hold(10);
    rd(A_PER, ticks(100, 0), "basic_period");
    rd(A_HIGH, ticks(30, 0), "basic_high");
    rd(A_STAT, 32'h1, "basic_stat");

    // prescaled
    wr(A_CTRL, 32'h0, 4'hF);
    wr(A_STAT, 32'h7, 4'hF);
    wr(A_PSC, 32'd9, 4'hF);
    wr(A_CTRL, 32'h1, 4'hF);
    cap_in = 1'b1; hold(250); cap_in = 1'b0; hold(750); cap_in = 1'b1; hold(250); cap_in = 1'b0; hold(20);
    rd(A_PER, ticks(1000, 9), "psc_period");
    rd(A_HIGH, ticks(250, 9), "psc_high");

    // overrun and set-vs-clear collision
    wr(A_CTRL, 32'h0, 4'hF);
    wr(A_STAT, 32'h7, 4'hF);
    wr(A_PSC, 32'd0, 4'hF);
    wr(A_CTRL, 32'h1, 4'hF);
    for (int k = 0; k < 3; k++) begin
      cap_in = 1'b1; hold(20); cap_in = 1'b0; hold(30);
    end
    rd(A_PER, ticks(50, 0), "ovr_period");
    rd(A_STAT, 32'h3, "ovr_stat");
    wr(A_STAT, 32'h3, 4'hF);
    rd(A_STAT, 32'h0, "w1c_clear");
    cap_in = 1'b1; hold(20); cap_in = 1'b0; hold(30);
    cap_in = 1'b1;
    repeat (ACT - 2) @(posedge clk);
    wr(A_STAT, 32'h3, 4'hF);
    rd(A_STAT, 32'h3, "set_beats_clear");
    rd(A_HIGH, ticks(20, 0), "collide_high");
    cap_in = 1'b0; hold(5);

    // timeout boundary, then a clean restart from IDLE
    wr(A_CTRL, 32'h0, 4'hF);
    wr(A_STAT, 32'h7, 4'hF);
    wr(A_TMO, 32'd50, 4'hF);
    wr(A_CTRL, 32'h1, 4'hF);
    cap_in = 1'b1;
    repeat (ACT + 48) @(posedge clk);
    rd(A_STAT, 32'h0, "tmo_before");
    rd(A_STAT, 32'h4, "tmo_at");
    rd(A_PER, ticks(50, 0), "tmo_keeps_period");
    wr(A_STAT, 32'h4, 4'hF);
    rd(A_STAT, 32'h0, "tmo_clear");
    cap_in = 1'b0; hold(10);
    cap_in = 1'b1; hold(10);
    rd(A_STAT, 32'h0, "no_first_edge_valid");
    hold(4); cap_in = 1'b0; hold(20); cap_in = 1'b1; hold(10);
    rd(A_PER, ticks(35, 0), "after_tmo_period");
    rd(A_HIGH, ticks(15, 0), "after_tmo_high");
    rd(A_STAT, 32'h1, "after_tmo_stat");
    wr(A_CTRL, 32'h0, 4'hF);

    // inverted input, then disable mid-measurement
    wr(A_STAT, 32'h7, 4'hF);
    wr(A_TMO, 32'd0, 4'hF);
    cap_in = 1'b1;
    wr(A_CTRL, 32'h2, 4'hF);
    hold(5);
    wr(A_CTRL, 32'h3, 4'hF);
    cap_in = 1'b0; hold(40); cap_in = 1'b1; hold(60); cap_in = 1'b0; hold(40); cap_in = 1'b1; hold(5);
    rd(A_PER, ticks(100, 0), "inv_period");
    rd(A_HIGH, ticks(40, 0), "inv_high");
    rd(A_STAT, 32'h1, "inv_stat");
    wr(A_STAT, 32'h1, 4'hF);
    wr(A_CTRL, 32'h2, 4'hF);
    hold(3);
    wr(A_CTRL, 32'h3, 4'hF);
    cap_in = 1'b0; hold(20);
    rd(A_STAT, 32'h0, "en_restart_idle");
    rd(A_PER, ticks(100, 0), "en_keeps_period");
    cap_in = 1'b1; hold(30); cap_in = 1'b0; hold(5);
    rd(A_PER, ticks(52, 0), "reen_period");
    rd(A_HIGH, ticks(22, 0), "reen_high");
    wr(A_CTRL, 32'h0, 4'hF);
    cap_in = 1'b0;

    // randomized pulse trains against the tick model
    for (int it = 0; it < 4; it++) begin
      int p, h, l, n;
      p = $urandom_range(0, 5);
      h = $urandom_range(3, 40);
      l = $urandom_range(3, 40);
      n = $urandom_range(1, 3);
      wr(A_CTRL, 32'h0, 4'hF);
      wr(A_STAT, 32'h7, 4'hF);
      wr(A_PSC, 32'(p), 4'hF);
      wr(A_CTRL, 32'h1, 4'hF);
      for (int k = 0; k <= n; k++) begin
        cap_in = 1'b1; hold(h); cap_in = 1'b0; hold(l);
      end
      rd(A_PER, ticks(h + l, p), $sformatf("rand_period_%0d", it));
      rd(A_HIGH, ticks(h, p), $sformatf("rand_high_%0d", it));
      rd(A_STAT, (n >= 2) ? 32'h3 : 32'h1, $sformatf("rand_stat_%0d", it));
    end

`ifdef STIM_CAPTURE_FILTER_EN
    wr(A_STAT, 32'h7, 4'hF);
    cap_in = 1'b1; hold(2); cap_in = 1'b0; hold(10);
    rd(A_STAT, 32'h0, "glitch_ignored");
    cap_in = 1'b1; hold(3); cap_in = 1'b0; hold(10);
    rd(A_STAT, 32'h1, "pulse3_seen");
`endif

    // reset in the middle of a measurement
    wr(A_PSC, 32'd7, 4'hF);
    cap_in = 1'b1; hold(5);
    rst = 1'b1; hold(2); rst = 1'b0;
    cap_in = 1'b0;
    rd(A_PSC, 32'd0, "rst_psc");
    rd(A_PER, 32'd0, "rst_period");
    rd(A_STAT, 32'd0, "rst_stat");
    rd(A_CTRL, 32'd0, "rst_ctrl");

    for (int i = 0; i < 10 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain pending=%0d need=0", sb.size());
    end
    @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
